// File: rtl/press_pkg.sv
// press_pkg: shared constants for the Precision Button Press front end.
//   LFSR_W            target LFSR width
//   LFSR_TAPS         feedback tap mask (bits 7,5,4,3 -> maximal length)
//   LFSR_DEFAULT_SEED reset value used when no seed is supplied
//   LFSR_ZERO_SUB     substitute loaded when the seed is zero (all-zero locks up)
package press_pkg;

    localparam int                LFSR_W            = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 8'b1011_1000;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 8'hA5;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB     = 8'h01;

    // One Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_init(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? LFSR_ZERO_SUB : seed;
    endfunction

endpackage

// File: rtl/press_target_gen_debounce.sv
// btn_debounce: two-flop synchronizer followed by a counting debouncer.
//   CLK    clock, rising edge
//   RST    asynchronous active-high reset
//   BTN    raw asynchronous button
//   stable accepted button level; changes only after DEBOUNCE_CYCLES
//          consecutive synchronized samples disagree with it
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic stable
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= BTN;
            s2 <= s1;
            // Any agreeing sample restarts the count, so only an unbroken
            // run of DEBOUNCE_CYCLES disagreeing samples flips the level.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/press_target_gen.sv
// press_target_gen: conditions the player button and generates the target
// bit stream, presenting both as aligned X/Y bits once per game tick.
//   CLK   clock, rising edge
//   RST   asynchronous active-high reset
//   BTN   raw asynchronous player button
//   X     debounced button level captured at each tick
//   Y     target bit for the current tick (LFSR MSB)
//   TICK  one-cycle strobe; X/Y/LFSR advance on the edge ending it
module press_target_gen
    import press_pkg::*;
#(
    parameter int                TICK_DIV        = 100000,
    parameter int                DEBOUNCE_CYCLES = 65536,
    parameter logic [LFSR_W-1:0] LFSR_SEED       = LFSR_DEFAULT_SEED
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic X,
    output logic Y,
    output logic TICK
);

    localparam int                TCNT_W    = $clog2(TICK_DIV);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [LFSR_W-1:0] LFSR_RST  = lfsr_init(LFSR_SEED);

    logic              stable;
    logic [TCNT_W-1:0] tcnt;
    logic [TCNT_W-1:0] tcnt_nxt;
    logic [LFSR_W-1:0] lfsr;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN),
        .stable(stable)
    );

    always_comb begin
        tcnt_nxt = (tcnt == TCNT_LAST) ? '0 : tcnt + TCNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tcnt <= '0;
            TICK <= 1'b0;
            X    <= 1'b0;
            Y    <= 1'b0;
            lfsr <= LFSR_RST;
        end else begin
            tcnt <= tcnt_nxt;
            // Registered from the next count so TICK is high exactly while
            // tcnt sits at its last value, with no decode glitches.
            TICK <= (tcnt_nxt == TCNT_LAST);
            if (TICK) begin
                // stable may change on this same edge; X deliberately takes
                // the pre-edge value and the new level lands next tick.
                X    <= stable;
                Y    <= lfsr[LFSR_W-1];
                lfsr <= lfsr_step(lfsr);
            end
        end
    end

endmodule

// File: tb/tb_press_target_gen.sv
// Scoreboard bench for press_target_gen (TICK_DIV=4, DEBOUNCE_CYCLES=4).
// A reference model predicts each tick's X/Y and pushes it into a queue; a
// monitor pops and compares on the cycle after every TICK strobe.
module tb_press_target_gen;

    localparam int TD = 4;
    localparam int DC = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN = 1'b0;
    logic X, Y, TICK;
    logic X0, Y0, TICK0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    press_target_gen #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC), .LFSR_SEED(8'hA5)) dut (
        .CLK(CLK), .RST(RST), .BTN(BTN), .X(X), .Y(Y), .TICK(TICK)
    );

    press_target_gen #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC), .LFSR_SEED(8'h00)) dut0 (
        .CLK(CLK), .RST(RST), .BTN(BTN), .X(X0), .Y(Y0), .TICK(TICK0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // x^8+x^6+x^5+x^4+1 polynomial, written as plain arithmetic on an int.
    function automatic int ref_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 8'hFF;
    endfunction

    // ---------------- reference model ----------------
    int         n         = 0;      // edges since reset release
    logic       m_stable  = 1'b0;
    int         last_flip = 0;
    int         m_lfsr    = 8'hA5;
    logic       hist[$];            // BTN seen at each edge
    logic       samp[$];            // synchronized sample used at each edge
    logic [1:0] exp_q[$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            n = 0; m_stable = 1'b0; last_flip = 0; m_lfsr = 8'hA5;
            hist.delete(); samp.delete(); exp_q.delete();
        end else begin
            logic s;
            bit   all_diff;
            n++;
            hist.push_back(BTN);
            s = (n >= 3) ? hist[n-3] : 1'b0;   // two-edge synchronizer delay
            samp.push_back(s);
            if (n % TD == 0) begin
                exp_q.push_back({m_stable, m_lfsr[7]});
                m_lfsr = ref_next(m_lfsr);
            end
            // Accept when the last DC samples, all taken since the previous
            // acceptance, disagree with the current level.
            if (n >= DC && last_flip <= n - DC) begin
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (samp[n-1-k] == m_stable) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable  = ~m_stable;
                    last_flip = n;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_tick = 1'b0;
    int   pops      = 0;

    always @(negedge CLK) begin
        if (RST) begin
            prev_tick = 1'b0;
        end else begin
            chk("tick", TICK, (n % TD) == TD - 1);
            chk("stable", dut.u_deb.stable, m_stable);
            chk("lfsr", dut.lfsr, m_lfsr);
            chk("lfsr_nonzero", dut.lfsr == 8'h00, 0);
            if (prev_tick) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    pops++;
                    chk("x", X, e[1]);
                    chk("y", Y, e[0]);
                end
            end
            prev_tick = TICK;
        end
    end

    // Zero-seed instance: LFSR starts at 01, so Y is 0 for 7 ticks, then 1.
    logic z_prev  = 1'b0;
    int   z_ticks = 0;

    always @(negedge CLK) begin
        if (RST) begin
            z_prev  = 1'b0;
            z_ticks = 0;
        end else begin
            if (z_prev) begin
                z_ticks++;
                if (z_ticks <= 8) chk("zero_seed_y", Y0, z_ticks == 8);
            end
            z_prev = TICK0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_x", X, 0);
        chk("rst_y", Y, 0);
        chk("rst_tick", TICK, 0);
        chk("rst_lfsr", dut.lfsr, 8'hA5);
        chk("rst_lfsr_zero_seed", dut0.lfsr, 8'h01);
        #1 RST = 1'b0;

        // Collision: BTN seen from edge 3 -> acceptance on edge 8, a tick edge
        repeat (2) @(negedge CLK);
        #1 BTN = 1'b1;
        repeat (6) @(negedge CLK);
        chk("collide_stable", dut.u_deb.stable, 1);
        chk("collide_x_old", X, 0);
        repeat (4) @(negedge CLK);
        chk("collide_x_new", X, 1);
        repeat (8) @(negedge CLK);

        // Release, then bounce: 3 high, 1 low, 2 high, low
        #1 BTN = 1'b0;
        repeat (20) @(negedge CLK);
        chk("release_x", X, 0);
        #1 BTN = 1'b1; repeat (3) @(negedge CLK);
        #1 BTN = 1'b0; repeat (1) @(negedge CLK);
        #1 BTN = 1'b1; repeat (2) @(negedge CLK);
        #1 BTN = 1'b0;
        repeat (12) @(negedge CLK);
        chk("bounce_stable", dut.u_deb.stable, 0);
        chk("bounce_x", X, 0);

        // Random runs of BTN
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            #1 if ($urandom_range(0, 5) == 0) BTN = ~BTN;
        end

        // Reset asserted mid-cycle during a TICK-high cycle
        waited = 0;
        do begin
            @(negedge CLK);
            waited++;
        end while (TICK !== 1'b1 && waited < 20);
        chk("wait_tick", TICK, 1);
        #1 RST = 1'b1;
        #1;
        chk("async_rst_x", X, 0);
        chk("async_rst_y", Y, 0);
        chk("async_rst_tick", TICK, 0);
        chk("async_rst_lfsr", dut.lfsr, 8'hA5);
        repeat (2) @(negedge CLK);
        #1 RST = 1'b0;

        // LFSR period: back to seed after exactly 255 ticks, not before
        for (int t = 1; t <= 255; t++) begin
            for (int c = 0; c < TD; c++) begin
                @(negedge CLK);
                if (c < TD - 1) #1 if ($urandom_range(0, 7) == 0) BTN = ~BTN;
            end
            if (t < 255) begin
                if (dut.lfsr == 8'hA5) chk("lfsr_early_repeat", t, 255);
            end else begin
                chk("lfsr_period", dut.lfsr, 8'hA5);
            end
        end

        chk("sb_activity", pops >= 300, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
